// File: rtl/mem_load_align_unit.sv
// -----------------------------------------------------------------------------
// mem_load_align_unit
//
// Memory-stage load unit between Execute and Writeback. It waits for the
// data-memory response of a load and aligns and sign/zero-extends the
// returned word. It flags misaligned, illegal-width and faulting loads. A
// response that arrives during an external stall is parked in a hold buffer.
// The orphaned response of a squashed load is drained. The result is
// registered into the MEM/WB pipeline register.
//
// Parameters:
//   XLEN    datapath width, 32 or 64
//   NBYTES  byte lanes per memory word (derived)
//   OFFW    address byte-offset bits (derived)
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   valid_i, mem_read_i   stage valid / instruction is a load
//   mem_width_i           0=BYTE 1=HALF 2=WORD 3=DWORD
//   mem_sign_i            1=sign-extend, 0=zero-extend
//   addr_i                load address
//   result_i              writeback value for non-loads
//   rd_i, rf_wr_en_i      destination register and write enable
//   stall_i, squash_i     external stall, kill of the stage instruction
//   rsp_valid_i           memory response pulse
//   rsp_rdata_i           naturally aligned read word
//   rsp_err_i             access fault
//   readwait_o            stage is holding for load data (combinational)
//   valid_o, rd_o, rf_wr_en_o, wdata_o, exc_o, exc_cause_o
//                         MEM/WB pipeline register
// -----------------------------------------------------------------------------
module mem_load_align_unit #(
  parameter int XLEN = 32,
  localparam int NBYTES = XLEN / 8,
  localparam int OFFW = $clog2(NBYTES)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic            mem_read_i,
  input  logic [1:0]      mem_width_i,
  input  logic            mem_sign_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] result_i,
  input  logic [4:0]      rd_i,
  input  logic            rf_wr_en_i,
  input  logic            stall_i,
  input  logic            squash_i,
  input  logic            rsp_valid_i,
  input  logic [XLEN-1:0] rsp_rdata_i,
  input  logic            rsp_err_i,
  output logic            readwait_o,
  output logic            valid_o,
  output logic [4:0]      rd_o,
  output logic            rf_wr_en_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            exc_o,
  output logic [3:0]      exc_cause_o
);

  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0] CAUSE_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_FAULT    = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] hold_data_q;
  logic            hold_err_q;

  logic            is_load;
  logic            load_active;
  logic            illegal_width;
  logic            misaligned;
  logic            load_legal;
  logic            advance;
  logic [OFFW-1:0] off;
  logic [XLEN-1:0] rdata;
  logic            rsp_err;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] word_ext;
  logic [XLEN-1:0] load_data;
  logic            exc;
  logic [3:0]      exc_cause;
  logic [XLEN-1:0] wdata;

  assign is_load       = valid_i && mem_read_i;
  assign load_active   = is_load && !squash_i;
  assign illegal_width = (mem_width_i == 2'd3) && (XLEN == 32);

  always_comb begin
    misaligned = 1'b0;
    case (mem_width_i)
      2'd1:    misaligned = addr_i[0];
      2'd2:    misaligned = |addr_i[1:0];
      2'd3:    misaligned = |addr_i[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign load_legal = !illegal_width && !misaligned;

  // In DRAIN the next response belongs to the squashed load, so any active
  // load keeps waiting even if a response shows up this cycle.
  assign readwait_o = load_active &&
                      ((state_q == DRAIN) ||
                       (load_legal && (state_q != HELD) &&
                        !((state_q == IDLE) && rsp_valid_i)));

  assign advance = !stall_i && (!readwait_o || squash_i);

  assign rdata   = (state_q == HELD) ? hold_data_q : rsp_rdata_i;
  assign rsp_err = (state_q == HELD) ? hold_err_q : (rsp_valid_i && rsp_err_i);

  // Only aligned accesses reach the data path, so shifting by the byte
  // offset lands every field width in the low bits of the word.
  assign off     = addr_i[OFFW-1:0];
  assign shifted = rdata >> {off, 3'b000};

  if (XLEN == 64) begin : g_word64
    assign word_ext = {{(XLEN-32){mem_sign_i & shifted[31]}}, shifted[31:0]};
  end else begin : g_word32
    assign word_ext = shifted;
  end

  always_comb begin
    load_data = shifted;
    case (mem_width_i)
      2'd0:    load_data = {{(XLEN-8){mem_sign_i & shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = {{(XLEN-16){mem_sign_i & shifted[15]}}, shifted[15:0]};
      2'd2:    load_data = word_ext;
      default: load_data = shifted;
    endcase
  end

  // Illegal width outranks misalignment, and both outrank a bus fault.
  always_comb begin
    exc       = 1'b0;
    exc_cause = 4'd0;
    wdata     = result_i;
    if (load_active) begin
      if (illegal_width) begin
        exc       = 1'b1;
        exc_cause = CAUSE_ILLEGAL;
      end else if (misaligned) begin
        exc       = 1'b1;
        exc_cause = CAUSE_MISALIGN;
      end else if (rsp_err) begin
        exc       = 1'b1;
        exc_cause = CAUSE_FAULT;
        wdata     = '0;
      end else begin
        wdata     = load_data;
      end
    end
  end

  // Hold/drain FSM and the MEM/WB register share one clocked process.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      hold_err_q  <= 1'b0;
      valid_o     <= 1'b0;
      rd_o        <= 5'd0;
      rf_wr_en_o  <= 1'b0;
      wdata_o     <= '0;
      exc_o       <= 1'b0;
      exc_cause_o <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rsp_valid_i && stall_i && load_active) begin
            state_q     <= HELD;
            hold_data_q <= rsp_rdata_i;
            hold_err_q  <= rsp_err_i;
          end else if (squash_i && is_load && load_legal && !rsp_valid_i) begin
            state_q <= DRAIN;
          end
        end
        HELD: begin
          if (squash_i || advance) begin
            state_q     <= IDLE;
            hold_data_q <= '0;
            hold_err_q  <= 1'b0;
          end
        end
        DRAIN: begin
          if (rsp_valid_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (advance) begin
        valid_o     <= valid_i & ~squash_i;
        rd_o        <= rd_i;
        rf_wr_en_o  <= rf_wr_en_i & ~exc;
        wdata_o     <= wdata;
        exc_o       <= exc;
        exc_cause_o <= exc_cause;
      end
    end
  end

endmodule
